long_fifo_sc: RTL
=================

# long_fifo_sc

Single-clock, parametrised-width/depth deep FIFO for the platform IP layer. It replaces per-4-bit-slice cascades with one inferred block-RAM array of arbitrary data width. It adds fill count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and an optional first-word-fall-through (FWFT) output stage. It sits between a single-clock producer and consumer wherever buffering deeper than distributed-RAM FIFOs is needed.

## Interface
- DSIZE, 10, data width in bits; any value ≥1.
- LENGTH, 16384, depth in words; power of 2, ≥4.
- AFULL_LVL, LENGTH-4, almost_full asserts when count ≥ AFULL_LVL.
- AEMPTY_LVL, 4, almost_empty asserts when count ≤ AEMPTY_LVL.

Ports:
- clock  in  1  sole clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  DSIZE  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request (standard) / acknowledge (FWFT).
- dout  out  DSIZE  read data.
- full  out  1  count == LENGTH.
- empty  out  1  no readable word.
- almost_full  out  1  count ≥ AFULL_LVL.
- almost_empty  out  1  count ≤ AEMPTY_LVL.
- count  out  $clog2(LENGTH)+1  words held, including the FWFT output register.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

## Operation
- Storage: LENGTH × DSIZE array; wr_ptr/rd_ptr are $clog2(LENGTH)+1 bits; the MSB is the wrap bit. Pointers wrap from LENGTH-1 to 0 with the wrap bit toggled.
- Write is accepted iff wr_en && !full; din is stored at wr_ptr and wr_ptr increments.
- Read is accepted iff rd_en && !empty.
- Both flags are the registered values from the current cycle. Consequences:
  - A write while full is rejected even if a read occurs in the same cycle.
  - A read while empty is rejected even if a write occurs in the same cycle.
- Rejected write sets overflow. Rejected read sets underflow. Both flags stay set until rst. FIFO contents, pointers and count are unaffected by rejected requests.
- count: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither are accepted. It never exceeds LENGTH and never goes below 0.
- full, almost_full and almost_empty are registered and derived from next-count, so they are exact in the same cycle as count.
- Standard mode: empty = (count == 0).
- FWFT mode:
  - A two-state prefetch control moves a word from the array into the output register: EMPTY_OUT (no valid word) -> VALID_OUT when the array is non-empty.
  - Outgoing transitions from VALID_OUT:
    - VALID_OUT -> VALID_OUT on an accepted read while the array is non-empty (refill in the same cycle).
    - VALID_OUT -> EMPTY_OUT on an accepted read while the array is empty.
  - empty = (state == EMPTY_OUT).
- Total capacity is LENGTH words in both modes.
- Reset (any time, including mid-transfer):
  - Discards all contents.
  - Pointers = 0, count = 0, dout = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0.
  - FWFT state = EMPTY_OUT.

## Timing
- Standard mode:
  - A write accepted at edge N is counted at N, so empty = 0 after edge N.
  - A read accepted at edge M presents its word on dout after edge M (1-cycle read latency).
  - dout holds its value when no read is accepted.
- FWFT mode:
  - A write accepted at edge N into an empty FIFO gives dout valid and empty = 0 after edge N+2.
  - For back-to-back data, a read accepted at edge M shows the next word on dout after edge M with no bubble. This sustains one word per cycle.
- Full throughput: one write and one read per cycle, indefinitely.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro LONG_FIFO_SC_FWFT_EN.
- Defined: FWFT output stage is compiled in. dout shows the head word whenever empty = 0, and rd_en acknowledges/consumes it.
- Undefined: standard mode. No prefetch logic; dout is valid one cycle after an accepted read.

## Test plan
- Reset then idle -> empty = 1, almost_empty = 1, count = 0, dout = 0, full = 0, overflow = 0, underflow = 0.
- Write 0x001..0x010 (16 words), then read 16 -> dout sequence is 0x001..0x010 in order, count returns to 0, empty = 1. Latency is 1 cycle in standard mode; in FWFT mode the first word appears 2 cycles after the first write.
- Fill to LENGTH, then issue wr_en + rd_en in the same cycle while full -> the write is rejected, overflow = 1, count = LENGTH-1, full = 0.
- Read while empty with a simultaneous write -> underflow = 1, count = 1, and the written word is read back intact.
- Stream random data at wr_en = rd_en = 1 for 3×LENGTH cycles -> no loss and no reordering, pointers wrap correctly, count stays constant, 1 word/cycle throughput.
- With AFULL_LVL = LENGTH-4 and AEMPTY_LVL = 4: almost_full rises at count = LENGTH-4 and almost_empty falls at count = 5. Asserting rst mid-stream returns every output to its reset value immediately.

Source files
------------

// File: rtl/long_fifo_sc.sv
// long_fifo_sc: single-clock deep FIFO on one inferred RAM array with fill count,
// almost-full/empty and sticky error flags. Define LONG_FIFO_SC_FWFT_EN for a first-word-fall-through output.
module long_fifo_sc #(
  parameter int DSIZE      = 10,
  parameter int LENGTH     = 16384,
  parameter int AFULL_LVL  = LENGTH - 4,
  parameter int AEMPTY_LVL = 4
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic [DSIZE-1:0]         din,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [DSIZE-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(LENGTH):0]  count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(LENGTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LEN_C = CW'(LENGTH);
  localparam logic [CW-1:0] AF_C  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AE_C  = CW'(AEMPTY_LVL);

  logic [DSIZE-1:0] mem [LENGTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             wr_acc, rd_acc;

  // Acceptance uses only this cycle's registered flags, never the other port's request.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc)      count_nxt = count + 1'b1;
    else if (rd_acc && !wr_acc) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      count        <= count_nxt;
      full         <= (count_nxt == LEN_C);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      if (wr_en && !wr_acc) overflow  <= 1'b1;
      if (rd_en && !rd_acc) underflow <= 1'b1;
    end
  end

`ifdef LONG_FIFO_SC_FWFT_EN
  typedef enum logic {EMPTY_OUT = 1'b0, VALID_OUT = 1'b1} out_state_t;
  out_state_t  state, state_nxt;
  logic [AW:0] wr_ptr_q;
  logic        arr_ne, fetch;

  // Prefetch sees writes one cycle late: keeps RAM read and write of a word
  // in different cycles and gives the two-cycle write-to-dout latency.
  assign arr_ne = (wr_ptr_q != rd_ptr);
  assign fetch  = arr_ne && ((state == EMPTY_OUT) || rd_acc);
  assign empty  = (state == EMPTY_OUT);

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY_OUT: if (arr_ne) state_nxt = VALID_OUT;
      VALID_OUT: if (rd_acc && !arr_ne) state_nxt = EMPTY_OUT;
      default:   state_nxt = EMPTY_OUT;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state    <= EMPTY_OUT;
      wr_ptr_q <= '0;
      rd_ptr   <= '0;
      dout     <= '0;
    end else begin
      state    <= state_nxt;
      wr_ptr_q <= wr_ptr;
      if (fetch) begin
        dout   <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      dout   <= '0;
      empty  <= 1'b1;
    end else begin
      empty <= (count_nxt == '0);
      if (rd_acc) begin
        dout   <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
`endif

endmodule
